// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator: shared period counter, per-channel duty codes double-buffered at period end.
// Optional PWM_MULTICANAL_DEFASAGEM_EN staggers channel phases evenly across the period.
//
// state      | meaning
// PARADO     | idle, outputs low, counter held at 0
// ATIVO      | running, enable high
// ENCERRANDO | enable dropped, finishing the current period
module pwm_multicanal #(
   parameter int N_CANAIS     = 4,
   parameter int W_LARGURA    = 3,
   parameter int CONF_PERIODO = 1250,
   parameter int PASSO        = 50
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          carrega,
   input  logic [N_CANAIS*W_LARGURA-1:0] largura,
   output logic [N_CANAIS-1:0]           pwm,
   output logic                          fim_periodo,
   output logic                          ocupado
);

   typedef enum logic [1:0] {PARADO, ATIVO, ENCERRANDO} estado_t;

   localparam int            WL        = W_LARGURA + 32;
   localparam logic [31:0]   ULTIMO    = 32'(CONF_PERIODO - 1);
   localparam logic [WL-1:0] PERIODO_L = WL'(CONF_PERIODO);
   localparam logic [WL-1:0] PASSO_L   = WL'(PASSO);

   estado_t                       estado_q, estado_d;
   logic [31:0]                   contagem_q, contagem_d;
   logic [N_CANAIS*W_LARGURA-1:0] pend_q, pend_d;
   logic [N_CANAIS*W_LARGURA-1:0] ativo_q, ativo_d;
   logic [N_CANAIS-1:0]           pwm_q, pwm_d;
   logic                          fim_q, fim_d;
   logic                          ocup_q, ocup_d;
   logic                          armado_q;

   logic                          ultimo_ciclo;
   logic                          transfere;
   logic                          carga;
   logic [31:0]                   fase;
   logic [WL-1:0]                 prod;
   logic [WL-1:0]                 limite;
`ifdef PWM_MULTICANAL_DEFASAGEM_EN
   logic [32:0]                   soma;
`endif

   always_comb begin
      estado_d     = estado_q;
      contagem_d   = contagem_q;
      ultimo_ciclo = (estado_q != PARADO) && (contagem_q == ULTIMO);
      transfere    = ultimo_ciclo || ((estado_q == PARADO) && enable);
      // the strobe on the first edge after reset release is discarded
      carga        = carrega && armado_q;

      case (estado_q)
         PARADO: begin
            if (enable) begin
               estado_d   = ATIVO;
               contagem_d = '0;
            end
         end
         ATIVO: begin
            contagem_d = ultimo_ciclo ? '0 : contagem_q + 32'd1;
            if (!enable) estado_d = ENCERRANDO;
         end
         ENCERRANDO: begin
            contagem_d = ultimo_ciclo ? '0 : contagem_q + 32'd1;
            if (enable)            estado_d = ATIVO;
            else if (ultimo_ciclo) estado_d = PARADO;
         end
         default: begin
            estado_d   = PARADO;
            contagem_d = '0;
         end
      endcase

      pend_d  = carga ? largura : pend_q;
      ativo_d = transfere ? pend_d : ativo_q;
      fim_d   = (estado_d != PARADO) && (contagem_d == ULTIMO);
      ocup_d  = (estado_d != PARADO);

      pwm_d  = '0;
      fase   = '0;
      prod   = '0;
      limite = '0;
`ifdef PWM_MULTICANAL_DEFASAGEM_EN
      soma   = '0;
`endif
      for (int k = 0; k < N_CANAIS; k++) begin
`ifdef PWM_MULTICANAL_DEFASAGEM_EN
         soma = {1'b0, contagem_q} + 33'(CONF_PERIODO) - 33'(k * (CONF_PERIODO / N_CANAIS));
         fase = (soma >= 33'(CONF_PERIODO)) ? 32'(soma - 33'(CONF_PERIODO)) : soma[31:0];
`else
         fase = contagem_q;
`endif
         prod   = WL'(ativo_q[k*W_LARGURA +: W_LARGURA]) * PASSO_L;
         limite = (prod >= PERIODO_L) ? PERIODO_L : prod;
         pwm_d[k] = (estado_q != PARADO) && (WL'(fase) < limite);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= PARADO;
         contagem_q <= '0;
         pend_q     <= '0;
         ativo_q    <= '0;
         pwm_q      <= '0;
         fim_q      <= 1'b0;
         ocup_q     <= 1'b0;
         armado_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         contagem_q <= contagem_d;
         pend_q     <= pend_d;
         ativo_q    <= ativo_d;
         pwm_q      <= pwm_d;
         fim_q      <= fim_d;
         ocup_q     <= ocup_d;
         armado_q   <= 1'b1;
      end
   end

   assign pwm         = pwm_q;
   assign fim_periodo = fim_q;
   assign ocupado     = ocup_q;

endmodule
